// File: rtl/stream_pkg.sv
// stream_pkg: shared defaults and state encoding for the result streamer.
//   DW_DEF  - default signed lane width
//   NL_DEF  - default lane count (the streamer is built for four lanes)
//   IDX_W   - width of the lane index
//   state_t - streamer FSM states: IDLE (nothing to send), SEND (dout valid)
package stream_pkg;

    localparam int DW_DEF = 8;
    localparam int NL_DEF = 4;
    localparam int IDX_W  = 2;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_t;

endpackage

// File: rtl/result_bank.sv
// result_bank: four-lane result register with a write enable and a
// lane-select read port. The full vector is also exposed so one bank
// can be copied into another in a single cycle.
//   clk, rst_n - clock and asynchronous active-low reset (bank clears to 0)
//   we         - write all lanes from wdata this cycle
//   wdata      - incoming vector, lane 0 in the low slot
//   sel        - lane to present on rdata
//   lanes      - stored vector
//   rdata      - stored lane selected by sel
module result_bank
    import stream_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int NL = NL_DEF
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    we,
    input  logic [NL-1:0][DW-1:0]   wdata,
    input  logic [IDX_W-1:0]        sel,
    output logic [NL-1:0][DW-1:0]   lanes,
    output logic signed [DW-1:0]    rdata
);

    logic [NL-1:0][DW-1:0] mem;

    // NOTE: this storage is reset on purpose: a reset must leave no stale
    // lane visible on dout, so the bank clears rather than just holding data.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values of its neighbours.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem <= '0;
        end else if (we) begin
            mem <= wdata;
        end
    end

    assign lanes = mem;
    assign rdata = mem[sel];

endmodule

// File: rtl/result_streamer.sv
// result_streamer: takes a four-lane result vector on a single-cycle load
// strobe and streams the lanes out one per handshake (f1 first, f4 last).
// A one-deep pending bank queues a second vector while the first streams;
// a load arriving with the pending bank full (and no final-lane handshake
// freeing it that cycle) is dropped and flagged on overrun.
//   clk, rst_n     - clock and asynchronous active-low reset
//   f1..f4         - signed result lanes, valid when load is high
//   load           - single-cycle strobe capturing f1..f4
//   dout           - lane currently offered (0 when not valid)
//   dout_valid     - dout holds a valid lane
//   dout_ready     - consumer accepts dout when high with dout_valid
//   dout_idx       - lane number of dout (0 = f1 .. 3 = f4)
//   dout_last      - dout is the final lane of its vector
//   busy           - streaming, or pending bank occupied
//   overrun        - combinational pulse in the cycle a load is dropped
module result_streamer
    import stream_pkg::*;
#(
    parameter int DW = DW_DEF,
    parameter int NL = NL_DEF
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic signed [DW-1:0] f1,
    input  logic signed [DW-1:0] f2,
    input  logic signed [DW-1:0] f3,
    input  logic signed [DW-1:0] f4,
    input  logic                 load,
    output logic signed [DW-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic [IDX_W-1:0]     dout_idx,
    output logic                 dout_last,
    output logic                 busy,
    output logic                 overrun
);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NL - 1);

    state_t             state, state_nxt;
    logic [IDX_W-1:0]   idx, idx_nxt;
    logic               pend_full, pend_full_nxt;

    logic               act_we, act_from_pend, pend_we, drop;
    logic               hs, at_last, end_hs;

    logic [NL-1:0][DW-1:0] in_vec, act_wdata, pend_lanes;
    logic [NL-1:0][DW-1:0] unused_act_lanes;
    logic signed [DW-1:0]  act_rdata, unused_pend_rdata;

    // Lane 0 (f1) sits in the low slot so the lane index selects it directly.
    assign in_vec[0] = f1;
    assign in_vec[1] = f2;
    assign in_vec[2] = f3;
    assign in_vec[3] = f4;

    assign hs      = dout_valid & dout_ready;
    assign at_last = (idx == LAST_IDX);
    assign end_hs  = hs & at_last;

    // Active is refilled either from the pending bank (queued vector goes
    // first) or straight from the inputs when nothing is queued.
    assign act_wdata = act_from_pend ? pend_lanes : in_vec;

    result_bank #(.DW(DW), .NL(NL)) u_active (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (act_we),
        .wdata (act_wdata),
        .sel   (idx),
        .lanes (unused_act_lanes),
        .rdata (act_rdata)
    );

    result_bank #(.DW(DW), .NL(NL)) u_pending (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (pend_we),
        .wdata (in_vec),
        .sel   (idx),
        .lanes (pend_lanes),
        .rdata (unused_pend_rdata)
    );

    // NOTE: every signal driven here gets a default first, so no path
    // through the case leaves one unassigned and no latch is inferred.
    always_comb begin
        state_nxt     = state;
        idx_nxt       = idx;
        pend_full_nxt = pend_full;
        act_we        = 1'b0;
        act_from_pend = 1'b0;
        pend_we       = 1'b0;
        drop          = 1'b0;

        case (state)
            IDLE: begin
                // Pending is always empty in IDLE, so a load goes straight
                // to the active bank.
                if (load) begin
                    act_we    = 1'b1;
                    idx_nxt   = '0;
                    state_nxt = SEND;
                end
            end

            SEND: begin
                if (end_hs) begin
                    idx_nxt = '0;
                    if (pend_full) begin
                        // Queued vector goes next; a simultaneous load
                        // takes the slot it just vacated.
                        act_we        = 1'b1;
                        act_from_pend = 1'b1;
                        if (load) begin
                            pend_we = 1'b1;
                        end else begin
                            pend_full_nxt = 1'b0;
                        end
                    end else if (load) begin
                        act_we = 1'b1;
                    end else begin
                        state_nxt = IDLE;
                    end
                end else begin
                    if (hs) begin
                        idx_nxt = idx + IDX_W'(1);
                    end
                    if (load) begin
                        if (!pend_full) begin
                            pend_we       = 1'b1;
                            pend_full_nxt = 1'b1;
                        end else begin
                            drop = 1'b1;
                        end
                    end
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            idx       <= '0;
            pend_full <= 1'b0;
        end else begin
            state     <= state_nxt;
            idx       <= idx_nxt;
            pend_full <= pend_full_nxt;
        end
    end

    assign dout_valid = (state == SEND);
    assign dout       = dout_valid ? act_rdata : '0;
    assign dout_idx   = idx;
    assign dout_last  = dout_valid & at_last;
    assign busy       = dout_valid | pend_full;
    assign overrun    = drop;

endmodule

// File: tb/tb_result_streamer.sv
// Testbench for result_streamer. A lane-level reference model holds the
// lanes still owed to the consumer in a queue; the number of whole vectors
// held is derived from its length, which decides whether a load is kept
// or dropped. Directed scenarios plus a randomized run are compared
// against the model every cycle.
module tb_result_streamer;

    localparam int DW = 8;

    typedef struct {
        logic signed [DW-1:0] val;
        int                   idx;
    } lane_t;

    logic                 clk;
    logic                 rst_n;
    logic signed [DW-1:0] f1, f2, f3, f4;
    logic                 load;
    logic signed [DW-1:0] dout;
    logic                 dout_valid;
    logic                 dout_ready;
    logic [1:0]           dout_idx;
    logic                 dout_last;
    logic                 busy;
    logic                 overrun;

    int checks   = 0;
    int errors   = 0;
    int hs_count = 0;
    int ov_count = 0;

    lane_t                q[$];     // lanes owed to the consumer, in order
    logic signed [DW-1:0] seen[$];  // lanes accepted by the consumer

    result_streamer #(.DW(DW), .NL(4)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .f1         (f1),
        .f2         (f2),
        .f3         (f3),
        .f4         (f4),
        .load       (load),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .dout_idx   (dout_idx),
        .dout_last  (dout_last),
        .busy       (busy),
        .overrun    (overrun)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // One clock cycle: drive inputs just after the rising edge, compare
    // outputs at the falling edge against the model, then advance the model
    // to what the next rising edge should do.
    task automatic step(input bit ld, input logic signed [DW-1:0] a,
                        input logic signed [DW-1:0] b, input logic signed [DW-1:0] c,
                        input logic signed [DW-1:0] d, input bit rdy);
        logic signed [DW-1:0] v[4];
        bit   exp_valid;
        bit   exp_ov;
        int   held;
        @(posedge clk);
        #1;
        load = ld; f1 = a; f2 = b; f3 = c; f4 = d; dout_ready = rdy;
        @(negedge clk);
        exp_valid = (q.size() > 0);
        checks++;
        if (dout_valid !== exp_valid) begin
            errors++;
            $display("FAIL dout_valid: got %0b expected %0b at %0t", dout_valid, exp_valid, $time);
        end
        checks++;
        if (busy !== exp_valid) begin
            errors++;
            $display("FAIL busy: got %0b expected %0b at %0t", busy, exp_valid, $time);
        end
        if (exp_valid) begin
            checks++;
            if (dout !== q[0].val) begin
                errors++;
                $display("FAIL dout: got %0d expected %0d at %0t", dout, q[0].val, $time);
            end
            checks++;
            if (dout_idx !== 2'(q[0].idx)) begin
                errors++;
                $display("FAIL dout_idx: got %0d expected %0d at %0t", dout_idx, q[0].idx, $time);
            end
            checks++;
            if (dout_last !== (q[0].idx == 3)) begin
                errors++;
                $display("FAIL dout_last: got %0b expected %0b at %0t", dout_last, (q[0].idx == 3), $time);
            end
        end
        // Model update: consume one lane on a handshake, then decide the load.
        if (exp_valid && rdy) begin
            seen.push_back(q[0].val);
            void'(q.pop_front());
            hs_count++;
        end
        exp_ov = 1'b0;
        if (ld) begin
            held = (q.size() + 3) / 4;
            if (held < 2) begin
                v[0] = a; v[1] = b; v[2] = c; v[3] = d;
                for (int i = 0; i < 4; i++) q.push_back('{val: v[i], idx: i});
            end else begin
                exp_ov = 1'b1;
            end
        end
        checks++;
        if (overrun !== exp_ov) begin
            errors++;
            $display("FAIL overrun: got %0b expected %0b at %0t", overrun, exp_ov, $time);
        end
        if (overrun === 1'b1) ov_count++;
    endtask

    task automatic idle(input int n, input bit rdy);
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, '0, '0, rdy);
    endtask

    task automatic test_reset;
        rst_n = 1'b0; load = 1'b0; dout_ready = 1'b0;
        f1 = '0; f2 = '0; f3 = '0; f4 = '0;
        #3;
        checks++;
        if ({dout, dout_valid, dout_idx, dout_last, busy, overrun} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: got dout=%0d v=%0b idx=%0d last=%0b busy=%0b ov=%0b expected all 0",
                     dout, dout_valid, dout_idx, dout_last, busy, overrun);
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(3, 1'b1);
    endtask

    task automatic test_basic;
        logic signed [DW-1:0] exp[$];
        exp = '{8'sd5, -8'sd3, 8'sd127, 8'sh80};
        seen.delete();
        step(1'b1, 8'sd5, -8'sd3, 8'sd127, 8'sh80, 1'b1);
        idle(6, 1'b1);
        checks++;
        if (seen.size() != 4) begin
            errors++;
            $display("FAIL basic_count: got %0d expected 4", seen.size());
        end
        for (int i = 0; i < 4 && i < seen.size(); i++) begin
            checks++;
            if (seen[i] !== exp[i]) begin
                errors++;
                $display("FAIL basic_lane%0d: got %0d expected %0d", i, seen[i], exp[i]);
            end
        end
    endtask

    task automatic test_backpressure;
        logic signed [DW-1:0] exp[$];
        int hs0;
        exp = '{8'sd5, -8'sd3, 8'sd127, 8'sh80};
        seen.delete();
        hs0 = hs_count;
        step(1'b1, 8'sd5, -8'sd3, 8'sd127, 8'sh80, 1'b1);
        for (int k = 0; k < 15; k++) step(1'b0, '0, '0, '0, '0, (k % 3) == 0);
        checks++;
        if (hs_count - hs0 != 4) begin
            errors++;
            $display("FAIL bp_handshakes: got %0d expected 4", hs_count - hs0);
        end
        for (int i = 0; i < 4 && i < seen.size(); i++) begin
            checks++;
            if (seen[i] !== exp[i]) begin
                errors++;
                $display("FAIL bp_lane%0d: got %0d expected %0d", i, seen[i], exp[i]);
            end
        end
    endtask

    task automatic test_queue;
        logic signed [DW-1:0] exp[$];
        int ov0;
        exp = '{8'sd1, 8'sd2, 8'sd3, 8'sd4, 8'sd9, 8'sd8, 8'sd7, 8'sd6};
        seen.delete();
        ov0 = ov_count;
        step(1'b1, 8'sd1, 8'sd2, 8'sd3, 8'sd4, 1'b1);
        step(1'b0, '0, '0, '0, '0, 1'b1);                 // idx 0
        step(1'b1, 8'sd9, 8'sd8, 8'sd7, 8'sd6, 1'b1);     // load B at idx 1
        idle(9, 1'b1);
        checks++;
        if (ov_count != ov0) begin
            errors++;
            $display("FAIL queue_overrun: got %0d pulses expected 0", ov_count - ov0);
        end
        checks++;
        if (seen.size() != 8) begin
            errors++;
            $display("FAIL queue_count: got %0d expected 8", seen.size());
        end
        for (int i = 0; i < 8 && i < seen.size(); i++) begin
            checks++;
            if (seen[i] !== exp[i]) begin
                errors++;
                $display("FAIL queue_lane%0d: got %0d expected %0d", i, seen[i], exp[i]);
            end
        end
    endtask

    task automatic test_overrun;
        logic signed [DW-1:0] exp[$];
        int ov0;
        exp = '{8'sd10, 8'sd11, 8'sd12, 8'sd13, 8'sd20, 8'sd21, 8'sd22, 8'sd23};
        seen.delete();
        ov0 = ov_count;
        step(1'b1, 8'sd10, 8'sd11, 8'sd12, 8'sd13, 1'b0);  // A
        step(1'b1, 8'sd20, 8'sd21, 8'sd22, 8'sd23, 1'b0);  // B -> pending
        step(1'b1, 8'sd30, 8'sd31, 8'sd32, 8'sd33, 1'b0);  // C dropped
        idle(12, 1'b1);
        checks++;
        if (ov_count - ov0 != 1) begin
            errors++;
            $display("FAIL overrun_pulses: got %0d expected 1", ov_count - ov0);
        end
        checks++;
        if (seen.size() != 8) begin
            errors++;
            $display("FAIL overrun_count: got %0d expected 8", seen.size());
        end
        for (int i = 0; i < 8 && i < seen.size(); i++) begin
            checks++;
            if (seen[i] !== exp[i]) begin
                errors++;
                $display("FAIL overrun_lane%0d: got %0d expected %0d", i, seen[i], exp[i]);
            end
        end
    endtask

    task automatic test_coincident;
        step(1'b1, -8'sd1, -8'sd2, -8'sd3, -8'sd4, 1'b1);
        idle(3, 1'b1);                                      // idx 0..2
        step(1'b1, 8'sd44, 8'sd55, 8'sd66, 8'sd77, 1'b1);   // load on idx 3 handshake
        step(1'b0, '0, '0, '0, '0, 1'b1);
        checks++;
        if (dout_valid !== 1'b1 || dout !== 8'sd44 || dout_idx !== 2'd0) begin
            errors++;
            $display("FAIL coincident_first: got v=%0b dout=%0d idx=%0d expected v=1 dout=44 idx=0",
                     dout_valid, dout, dout_idx);
        end
        idle(6, 1'b1);
    endtask

    task automatic test_reset_mid;
        step(1'b1, 8'sd1, 8'sd2, 8'sd3, 8'sd4, 1'b1);
        step(1'b0, '0, '0, '0, '0, 1'b1);                   // idx 0
        step(1'b1, 8'sd5, 8'sd6, 8'sd7, 8'sd8, 1'b1);       // idx 1, pending loaded
        step(1'b0, '0, '0, '0, '0, 1'b0);                   // sitting at idx 2
        checks++;
        if (dout_idx !== 2'd2 || busy !== 1'b1) begin
            errors++;
            $display("FAIL midreset_setup: got idx=%0d busy=%0b expected idx=2 busy=1", dout_idx, busy);
        end
        rst_n = 1'b0; load = 1'b0;
        #1;
        checks++;
        if ({dout, dout_valid, dout_idx, dout_last, busy, overrun} !== '0) begin
            errors++;
            $display("FAIL midreset_outputs: got dout=%0d v=%0b idx=%0d last=%0b busy=%0b ov=%0b expected all 0",
                     dout, dout_valid, dout_idx, dout_last, busy, overrun);
        end
        q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        idle(6, 1'b1);
        checks++;
        if (dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL midreset_replay: got dout_valid=%0b expected 0", dout_valid);
        end
        // First load after reset streams with one-cycle latency.
        step(1'b1, 8'sd100, -8'sd100, 8'sd0, 8'sd1, 1'b1);
        step(1'b0, '0, '0, '0, '0, 1'b1);
        checks++;
        if (dout !== 8'sd100 || dout_valid !== 1'b1) begin
            errors++;
            $display("FAIL midreset_reload: got v=%0b dout=%0d expected v=1 dout=100", dout_valid, dout);
        end
        idle(5, 1'b1);
    endtask

    task automatic test_random;
        for (int i = 0; i < 600; i++) begin
            step(($urandom_range(0, 9) < 3), DW'($urandom), DW'($urandom),
                 DW'($urandom), DW'($urandom), ($urandom_range(0, 3) != 0));
        end
        idle(12, 1'b1);
        checks++;
        if (q.size() != 0 || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL random_drain: got %0d lanes owed, valid=%0b expected 0, 0", q.size(), dout_valid);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_backpressure();
        test_queue();
        test_overrun();
        test_coincident();
        test_reset_mid();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
